// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - note-event strobes and score outputs of score_keeper
interface score_keeper_if;
   logic       hit;
   logic       miss;
   logic       clear;
   logic [9:0] score;
   logic [6:0] combo;
   logic [2:0] mult;
   logic       score_upd;
   logic       score_sat;

   modport master (
      output hit, miss, clear,
      input  score, combo, mult, score_upd, score_sat
   );

   modport slave (
      input  hit, miss, clear,
      output score, combo, mult, score_upd, score_sat
   );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - two-stage hit/miss score, combo and multiplier accumulator
// Optional: define SCORE_MISS_PENALTY_EN to make a miss cost one point.
module score_keeper #(
   parameter int SCORE_MAX   = 999,
   parameter int BASE_POINTS = 1,
   parameter int COMBO_STEP  = 10,
   parameter int MULT_MAX    = 4
) (
   input  logic         Clk,
   input  logic         Reset_n,
   score_keeper_if.slave sk
);

   localparam int SW = (COMBO_STEP > 1) ? $clog2(COMBO_STEP) : 1;

   logic          ev_valid;
   logic          ev_hit;
   logic [SW-1:0] step;
   logic [12:0]   pts;
   logic [12:0]   sum;
   logic [9:0]    hit_score;
   logic          step_wrap;

   // Points use the multiplier in force before this hit advances it.
   always_comb begin
      pts       = 13'(BASE_POINTS) * 13'(sk.mult);
      sum       = 13'(sk.score) + pts;
      hit_score = (sum >= 13'(SCORE_MAX)) ? 10'(SCORE_MAX) : sum[9:0];
      step_wrap = (step == SW'(COMBO_STEP - 1));
   end

`ifdef SCORE_MISS_PENALTY_EN
   logic [9:0] miss_score;
   always_comb begin
      miss_score = (sk.score == 10'd0) ? 10'd0 : sk.score - 10'd1;
   end
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ev_valid     <= 1'b0;
         ev_hit       <= 1'b0;
         step         <= '0;
         sk.score     <= 10'd0;
         sk.combo     <= 7'd0;
         sk.mult      <= 3'd1;
         sk.score_upd <= 1'b0;
         sk.score_sat <= 1'b0;
      end else if (sk.clear) begin
         ev_valid     <= 1'b0;
         ev_hit       <= 1'b0;
         step         <= '0;
         sk.score     <= 10'd0;
         sk.combo     <= 7'd0;
         sk.mult      <= 3'd1;
         sk.score_upd <= 1'b0;
         sk.score_sat <= 1'b0;
      end else begin
         // A simultaneous hit and miss is judged a miss.
         ev_valid     <= sk.hit | sk.miss;
         ev_hit       <= sk.hit & ~sk.miss;
         sk.score_upd <= ev_valid;
         if (ev_valid) begin
            if (ev_hit) begin
               sk.score     <= hit_score;
               sk.score_sat <= sk.score_sat | (hit_score == 10'(SCORE_MAX));
               if (sk.combo != 7'd127) begin
                  sk.combo <= sk.combo + 7'd1;
               end
               step <= step_wrap ? '0 : step + SW'(1);
               if (step_wrap && (sk.mult < 3'(MULT_MAX))) begin
                  sk.mult <= sk.mult + 3'd1;
               end
            end else begin
               sk.combo <= 7'd0;
               sk.mult  <= 3'd1;
               step     <= '0;
`ifdef SCORE_MISS_PENALTY_EN
               sk.score     <= miss_score;
               sk.score_sat <= (miss_score >= 10'(SCORE_MAX));
`else
               sk.score     <= sk.score;
               sk.score_sat <= sk.score_sat;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - vector table, corner sequences and random run against a model
module tb_score_keeper;

   localparam int SMAX  = 999;
   localparam int BASE  = 1;
   localparam int STEP  = 10;
   localparam int MMAX  = 4;
`ifdef SCORE_MISS_PENALTY_EN
   localparam int PEN = 1;
`else
   localparam int PEN = 0;
`endif

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   score_keeper_if sk();

   score_keeper #(
      .SCORE_MAX(SMAX), .BASE_POINTS(BASE), .COMBO_STEP(STEP), .MULT_MAX(MMAX)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .sk(sk)
   );

   int checks = 0;
   int errors = 0;

   // Model: hits since last miss/clear decide combo and multiplier directly.
   int m_score, m_h, m_sat, m_upd, m_s1v, m_s1h;

   function automatic int m_mult(input int h);
      int v;
      v = 1 + h / STEP;
      return (v > MMAX) ? MMAX : v;
   endfunction

   function automatic int m_combo(input int h);
      return (h > 127) ? 127 : h;
   endfunction

   task automatic model_reset();
      m_score = 0; m_h = 0; m_sat = 0; m_upd = 0; m_s1v = 0; m_s1h = 0;
   endtask

   task automatic model_edge(input logic h, input logic m, input logic c);
      if (c) begin
         model_reset();
      end else begin
         m_upd = m_s1v;
         if (m_s1v != 0) begin
            if (m_s1h != 0) begin
               m_score = m_score + BASE * m_mult(m_h);
               if (m_score > SMAX) m_score = SMAX;
               m_h = m_h + 1;
               if (m_score == SMAX) m_sat = 1;
            end else begin
               m_h = 0;
               if (PEN != 0) begin
                  m_score = (m_score > 0) ? m_score - 1 : 0;
                  m_sat = (m_score >= SMAX) ? 1 : 0;
               end
            end
         end
         m_s1v = (h | m) ? 1 : 0;
         m_s1h = (h & ~m) ? 1 : 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".score"}, 32'(sk.score), 32'(m_score));
      chk({tag, ".combo"}, 32'(sk.combo), 32'(m_combo(m_h)));
      chk({tag, ".mult"}, 32'(sk.mult), 32'(m_mult(m_h)));
      chk({tag, ".upd"}, 32'(sk.score_upd), 32'(m_upd));
      chk({tag, ".sat"}, 32'(sk.score_sat), 32'(m_sat));
   endtask

   task automatic step(input logic h, input logic m, input logic c);
      sk.hit = h; sk.miss = m; sk.clear = c;
      @(posedge Clk);
      #1;
      model_edge(h, m, c);
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic h, m, c;
      int   sc, co, mu;
      logic up, sa;
   } vec_t;

   vec_t tbl[9];

   initial begin
      sk.hit = 1'b0; sk.miss = 1'b0; sk.clear = 1'b0;
      model_reset();

      tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1, 1, 1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 2, 2, 1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 2 - PEN, 0, 1, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 2 - PEN, 0, 1, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 0, 0, 1, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0};

      repeat (2) @(posedge Clk);
      #1;
      chk("rst.score", 32'(sk.score), 0);
      chk("rst.combo", 32'(sk.combo), 0);
      chk("rst.mult", 32'(sk.mult), 1);
      chk("rst.upd", 32'(sk.score_upd), 0);
      chk("rst.sat", 32'(sk.score_sat), 0);
      #3 Reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         step(tbl[i].h, tbl[i].m, tbl[i].c);
         chk($sformatf("vec%0d.score", i), 32'(sk.score), 32'(tbl[i].sc));
         chk($sformatf("vec%0d.combo", i), 32'(sk.combo), 32'(tbl[i].co));
         chk($sformatf("vec%0d.mult", i), 32'(sk.mult), 32'(tbl[i].mu));
         chk($sformatf("vec%0d.upd", i), 32'(sk.score_upd), 32'(tbl[i].up));
         chk($sformatf("vec%0d.sat", i), 32'(sk.score_sat), 32'(tbl[i].sa));
      end

      // Multiplier ramp: hit 11 is the first worth 2.
      step(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 40; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (i == 11) chk("ramp.after10", 32'(sk.score), 10);
         if (i == 12) chk("ramp.after11", 32'(sk.score), 12);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("ramp.score", 32'(sk.score), 100);
      chk("ramp.combo", 32'(sk.combo), 40);
      chk("ramp.mult", 32'(sk.mult), 4);

      // 25 hits: 10*1 + 10*2 + 5*3 = 45 at multiplier 3, then hit+miss.
      step(1'b0, 1'b0, 1'b1);
      hits(25);
      step(1'b0, 1'b0, 1'b0);
      chk("miss.pre_score", 32'(sk.score), 45);
      chk("miss.pre_mult", 32'(sk.mult), 3);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("miss.score", 32'(sk.score), 32'(45 - PEN));
      chk("miss.combo", 32'(sk.combo), 0);
      chk("miss.mult", 32'(sk.mult), 1);
      chk("miss.upd", 32'(sk.score_upd), 1);

      // Saturation.
      step(1'b0, 1'b0, 1'b1);
      hits(265);
      chk("sat.after264", 32'(sk.score), 996);
      chk("sat.flag_pre", 32'(sk.score_sat), 0);
      step(1'b0, 1'b0, 1'b0);
      chk("sat.score", 32'(sk.score), 999);
      chk("sat.flag", 32'(sk.score_sat), 1);
      chk("sat.combo", 32'(sk.combo), 127);
      chk("sat.mult", 32'(sk.mult), 4);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("sat.extra_upd", 32'(sk.score_upd), 1);
      chk("sat.extra_score", 32'(sk.score), 999);

      // Clear with a hit pending in stage 1 and another hit alongside.
      hits(3);
      step(1'b1, 1'b0, 1'b1);
      chk("clr.score", 32'(sk.score), 0);
      chk("clr.combo", 32'(sk.combo), 0);
      chk("clr.mult", 32'(sk.mult), 1);
      chk("clr.upd", 32'(sk.score_upd), 0);
      chk("clr.sat", 32'(sk.score_sat), 0);
      step(1'b0, 1'b0, 1'b0);
      chk("clr.next_score", 32'(sk.score), 0);
      chk("clr.next_upd", 32'(sk.score_upd), 0);

      // Asynchronous reset between edges during a burst.
      hits(6);
      sk.hit = 1'b0;
      #3 Reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst.score", 32'(sk.score), 0);
      chk("arst.combo", 32'(sk.combo), 0);
      chk("arst.mult", 32'(sk.mult), 1);
      chk("arst.upd", 32'(sk.score_upd), 0);
      chk("arst.sat", 32'(sk.score_sat), 0);
      #2 Reset_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("arst.first_hit", 32'(sk.score), 1);
      chk("arst.first_upd", 32'(sk.score_upd), 1);

      // Random run against the model.
      step(1'b0, 1'b0, 1'b1);
      chk_model("rnd.start");
      for (int i = 0; i < 3000; i++) begin
         step(1'(($urandom % 100) < 70), 1'(($urandom % 100) < 12), 1'(($urandom % 1000) < 3));
         chk_model($sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
